// File: rtl/cp0_pkg.sv
// CP0 interrupt-unit shared definitions: register numbers, field positions,
// exception codes and the default handler address.
package cp0_pkg;

  localparam logic [4:0]  REG_STATUS = 5'd12;
  localparam logic [4:0]  REG_CAUSE  = 5'd13;
  localparam logic [4:0]  REG_EPC    = 5'd14;

  localparam int          BIT_IE     = 0;
  localparam int          BIT_EXL    = 1;
  localparam int          IM_LO      = 8;

  localparam logic [4:0]  EXC_INT    = 5'd0;
  localparam logic [31:0] HANDLER_BASE_DEF = 32'h8000_0180;
  localparam logic [31:0] EPC_MASK   = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  function automatic logic [31:0] status_word(status_t s);
    return {16'h0, s.im, 6'h0, s.exl, s.ie};
  endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// CP0 access bus between the pipeline (master) and the interrupt unit (slave).
interface interrupt_unit_if #(
  parameter int NUM_LINES = 8
);
  logic [NUM_LINES-1:0] interrupt_lines;
  logic [4:0]           rd_regnum;
  logic [31:0]          rd_data;
  logic [4:0]           wr_regnum;
  logic [31:0]          wr_data;
  logic                 MTC0;
  logic                 ERET;
  logic                 stall;
  logic [31:0]          next_pc;
  logic                 takenInterrupt;
  logic [31:0]          handler_pc;
  logic [31:0]          EPC;

  modport master (
    output interrupt_lines, rd_regnum, wr_regnum, wr_data, MTC0, ERET, stall, next_pc,
    input  rd_data, takenInterrupt, handler_pc, EPC
  );

  modport slave (
    input  interrupt_lines, rd_regnum, wr_regnum, wr_data, MTC0, ERET, stall, next_pc,
    output rd_data, takenInterrupt, handler_pc, EPC
  );
endinterface

// File: rtl/intr_prio_enc.sv
// Lowest-index-wins priority encoder over the pending, unmasked lines.
module intr_prio_enc #(
  parameter int NUM_LINES = 8
) (
  input  logic [NUM_LINES-1:0] i_req,
  output logic                 o_valid,
  output logic [2:0]           o_idx
);
  always_comb begin
    o_idx = 3'd0;
    for (int i = NUM_LINES - 1; i >= 0; i--)
      if (i_req[i]) o_idx = i[2:0];
  end

  assign o_valid = |i_req;
endmodule

// File: rtl/interrupt_unit.sv
// CP0 interrupt unit: Status/Cause/EPC, line sampling, accept and ERET.
// Define INTR_VECTOR_EN to vector handler_pc by the highest-priority pending line.
module interrupt_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_LINES    = 8,
  parameter logic [31:0] HANDLER_BASE = HANDLER_BASE_DEF
) (
  input  logic             clock,
  input  logic             reset,
  interrupt_unit_if.slave  bus
);
  logic [NUM_LINES-1:0] r_ip_q;
  status_t              r_status;
  logic [31:0]          r_epc;
  logic [4:0]           r_exccode;

  logic [7:0]  w_ip8;
  logic [7:0]  w_req8;
  logic        w_pending;
  logic        w_taken;

  always_comb begin
    w_ip8 = '0;
    w_ip8[NUM_LINES-1:0] = r_ip_q;
  end

  assign w_req8    = w_ip8 & r_status.im;
  assign w_pending = |w_req8;
  assign w_taken   = r_status.ie & ~r_status.exl & w_pending & ~bus.stall;

  // An accepted interrupt squashes this cycle's ERET/MTC0; they re-execute from EPC.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ip_q    <= '0;
      r_status  <= '0;
      r_epc     <= '0;
      r_exccode <= '0;
    end else begin
      r_ip_q <= bus.interrupt_lines;
      if (w_taken) begin
        r_status.exl <= 1'b1;
        r_epc        <= bus.next_pc & EPC_MASK;
        r_exccode    <= EXC_INT;
      end else begin
        if (bus.ERET) r_status.exl <= 1'b0;
        if (bus.MTC0) begin
          case (bus.wr_regnum)
            REG_STATUS: begin
              r_status.ie  <= bus.wr_data[BIT_IE];
              r_status.exl <= bus.wr_data[BIT_EXL] & ~bus.ERET;
              r_status.im  <= bus.wr_data[IM_LO +: 8];
            end
            REG_EPC: r_epc <= bus.wr_data & EPC_MASK;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    case (bus.rd_regnum)
      REG_STATUS: bus.rd_data = status_word(r_status);
      REG_CAUSE:  bus.rd_data = {16'h0, w_ip8, 1'b0, r_exccode, 2'b00};
      REG_EPC:    bus.rd_data = r_epc;
      default:    bus.rd_data = '0;
    endcase
  end

  assign bus.takenInterrupt = w_taken;
  assign bus.EPC            = r_epc;

`ifdef INTR_VECTOR_EN
  logic       w_vld;
  logic [2:0] w_idx;

  intr_prio_enc #(.NUM_LINES(NUM_LINES)) u_prio (
    .i_req   (w_req8[NUM_LINES-1:0]),
    .o_valid (w_vld),
    .o_idx   (w_idx)
  );

  assign bus.handler_pc = w_vld ? HANDLER_BASE + {24'h0, w_idx, 5'h0} : HANDLER_BASE;
`else
  assign bus.handler_pc = HANDLER_BASE;
`endif

endmodule

// File: tb/tb_interrupt_unit.sv
// Directed bench for interrupt_unit: expectations queued at stimulus, popped at sample.
module tb_interrupt_unit;
  localparam logic [31:0] BASE = 32'h8000_0180;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  interrupt_unit_if #(.NUM_LINES(8)) bus ();

  interrupt_unit #(.NUM_LINES(8), .HANDLER_BASE(BASE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, input string tag, input logic [31:0] v);
    bus.rd_regnum = r;
    sb_push(tag, v);
    #1;
    sb_check(bus.rd_data);
  endtask

  task automatic chk_taken(input string tag, input logic v);
    sb_push(tag, {31'h0, v});
    #1;
    sb_check({31'h0, bus.takenInterrupt});
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    bus.MTC0 = 1'b1; bus.wr_regnum = r; bus.wr_data = d;
    tick();
    bus.MTC0 = 1'b0;
  endtask

  initial begin
    bus.interrupt_lines = 8'hFF;
    bus.rd_regnum = 5'd0; bus.wr_regnum = 5'd0; bus.wr_data = '0;
    bus.MTC0 = 1'b0; bus.ERET = 1'b0; bus.stall = 1'b0; bus.next_pc = '0;

    // Reset with all lines high
    tick(); tick();
    chk_taken("rst_taken", 1'b0);
    rd(5'd12, "rst_status", 32'h0);
    rd(5'd13, "rst_cause", 32'h0);
    rd(5'd14, "rst_epc", 32'h0);
    sb_push("rst_hpc", BASE); sb_check(bus.handler_pc);

    reset = 1'b1;
    bus.interrupt_lines = 8'h00;
    tick();

    // Basic accept on line 7
    mtc0(5'd12, 32'h0000_8001);
    bus.interrupt_lines = 8'h80;
    bus.next_pc = 32'h0040_0100;
    chk_taken("pre_edge_taken", 1'b0);
    tick();
    chk_taken("accept_taken", 1'b1);
    tick();
    chk_taken("accept_one_cycle", 1'b0);
    sb_push("accept_epc", 32'h0040_0100); sb_check(bus.EPC);
    rd(5'd12, "accept_status", 32'h0000_8003);
    rd(5'd13, "accept_cause", 32'h0000_8000);

    // ERET with line dropped
    bus.interrupt_lines = 8'h00;
    bus.ERET = 1'b1;
    tick();
    bus.ERET = 1'b0;
    rd(5'd12, "eret_status", 32'h0000_8001);
    chk_taken("eret_no_int", 1'b0);

    // Re-entry with line held across ERET
    bus.interrupt_lines = 8'h80;
    tick();
    chk_taken("reraise_taken", 1'b1);
    bus.next_pc = 32'h0040_0104;
    tick();
    chk_taken("handler_blocks", 1'b0);
    bus.ERET = 1'b1;
    tick();
    bus.ERET = 1'b0;
    chk_taken("reentry_taken", 1'b1);

    // Collision: accept + ERET + MTC0 EPC in the same cycle
    bus.ERET = 1'b1;
    bus.MTC0 = 1'b1; bus.wr_regnum = 5'd14; bus.wr_data = 32'h0000_1234;
    bus.next_pc = 32'h0040_0200;
    tick();
    bus.ERET = 1'b0; bus.MTC0 = 1'b0;
    sb_push("collide_epc", 32'h0040_0200); sb_check(bus.EPC);
    rd(5'd12, "collide_status", 32'h0000_8003);

    // Masking: IM=0, line 7 high
    mtc0(5'd12, 32'h0000_0001);
    chk_taken("masked_0", 1'b0);
    tick();
    chk_taken("masked_1", 1'b0);

    // Stall for 3 cycles
    bus.stall = 1'b1;
    mtc0(5'd12, 32'h0000_8001);
    chk_taken("stall_0", 1'b0);
    tick();
    chk_taken("stall_1", 1'b0);
    tick();
    chk_taken("stall_2", 1'b0);
    bus.stall = 1'b0;
    bus.next_pc = 32'h0040_0300;
    chk_taken("stall_release", 1'b1);
    tick();
    chk_taken("stall_accepted", 1'b0);
    sb_push("stall_epc", 32'h0040_0300); sb_check(bus.EPC);

    // Vectoring: lines 2 and 5 pending and unmasked, IE off
    bus.interrupt_lines = 8'h24;
    mtc0(5'd12, 32'h0000_2400);
`ifdef INTR_VECTOR_EN
    sb_push("vector_hpc", 32'h8000_01C0);
`else
    sb_push("vector_hpc", BASE);
`endif
    sb_check(bus.handler_pc);
    rd(5'd13, "vector_cause", 32'h0000_2400);
    chk_taken("vector_ie_off", 1'b0);

    // Asynchronous reset mid-handler
    mtc0(5'd12, 32'h0000_2403);
    rd(5'd12, "handler_status", 32'h0000_2403);
    #1;
    reset = 1'b0;
    #1;
    rd(5'd12, "async_rst_status", 32'h0);
    sb_push("async_rst_epc", 32'h0); sb_check(bus.EPC);
    chk_taken("async_rst_taken", 1'b0);
    tick();
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/interrupt_unit.md
# interrupt_unit

- Processor-side counterpart to the memory-mapped interrupt sources, such as the cycle timer.
- Samples the hardware interrupt lines, applies Status masking and the global enable, and raises `takenInterrupt` to redirect the pipeline.
- On an interrupt, records EPC and Cause; on ERET, returns control.
- Sits beside the register file and is accessed by MFC0/MTC0.

## Interface
Parameters:
- `NUM_LINES`, 8: hardware interrupt inputs, mapped to Cause.IP/Status.IM bits [15:8]; legal range 1–8.
- `HANDLER_BASE`, 32'h8000_0180: handler address.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `interrupt_lines`  in  NUM_LINES  level-sensitive requests; bit 0 is Cause bit 8.
- `rd_regnum`  in  5  CP0 register read select.
- `rd_data`  out  32  CP0 read data.
- `wr_regnum`  in  5  CP0 register write select.
- `wr_data`  in  32  MTC0 data.
- `MTC0`  in  1  write strobe.
- `ERET`  in  1  exception return.
- `stall`  in  1  pipeline stalled; interrupt not accepted.
- `next_pc`  in  32  address to resume at; captured into EPC.
- `takenInterrupt`  out  1  redirect the pipeline this cycle.
- `handler_pc`  out  32  redirect target.
- `EPC`  out  32  current EPC, used as the ERET target.

## Operation
Registers:
- Status (reg 12): IE bit 0, EXL bit 1, IM [15:8]; all other bits read 0.
- Cause (reg 13): IP [15:8], ExcCode [6:2]; all other bits read 0.
- EPC (reg 14): 32 bits, with [1:0] forced to 0.

Interrupt lines:
- `ip_q` <= `interrupt_lines` every cycle; this register is the only synchronizer.
- Cause.IP reads `ip_q` live.
- Unused IP bits above NUM_LINES read 0.

Accept and return:
- `pending` = |(`ip_q` & IM).
- `takenInterrupt` = IE & ~EXL & `pending` & ~`stall`; combinational.
- On a clock edge with `takenInterrupt`=1: EXL<=1, EPC<=`next_pc`, ExcCode<=0.
- `ERET`: EXL<=0 on the next edge.
- `EPC` output always equals the EPC register.

MTC0 writes:
- Reg 12 updates IE, EXL and IM.
- Reg 14 updates EPC.
- Reg 13 writes are ignored; IP is hardware-owned.
- Writes to other register numbers are ignored.

Reads:
- `rd_data` is a combinational mux on `rd_regnum`.
- Unimplemented register numbers return 0.

Same-edge priority: `reset` > `takenInterrupt` > `ERET` > `MTC0`.
- An interrupt accepted in a cycle cancels that cycle's ERET and MTC0; their instruction is squashed and re-executed from EPC.
- ERET together with an MTC0 to Status: EXL is cleared, and IE/IM come from `wr_data`.

States, implied by EXL:
- NORMAL (EXL=0) goes to HANDLER when `takenInterrupt` is high.
- HANDLER goes to NORMAL on ERET, or on an MTC0 that clears EXL.
- HANDLER blocks further acceptance.

Reset: Status=0, Cause=0, EPC=0, `ip_q`=0. As a result `takenInterrupt`=0, `handler_pc`=HANDLER_BASE, `EPC`=0 and `rd_data` is driven by the mux.

## Timing
- A line rise at edge N is visible in `ip_q` after edge N.
- `takenInterrupt` may assert in cycle N+1 (latency 1), provided IE=1, EXL=0, IM is set and `stall`=0.
- Acceptance commits at the end of the assertion cycle; `takenInterrupt` is never high for two consecutive cycles.
- A source must hold its line until software acknowledges it at the source. A line that drops before acceptance is lost; this is not an error.
- A `stall` that persists delays acceptance. The request is re-evaluated every cycle.
- Reset assertion mid-handler clears state asynchronously. `takenInterrupt` drops immediately.

## Configuration
`INTR_VECTOR_EN`:
- Defined: `handler_pc` = HANDLER_BASE + 32×k, where k is the lowest-numbered pending unmasked line (line 0 highest priority). ExcCode is unchanged.
- With `pending`=0, `handler_pc` = HANDLER_BASE.
- Undefined: `handler_pc` is always HANDLER_BASE and the priority encoder is not instantiated.

## Structure
Shared package `cp0_pkg`:
- Register numbers: STATUS=12, CAUSE=13, EPC=14.
- Bit positions: IE, EXL, IM/IP low=8.
- ExcCode value INT=0.
- Default HANDLER_BASE.

Sub-module `intr_prio_enc`:
- Parameterised NUM_LINES-bit lowest-index priority encoder.
- Outputs `valid` and a 3-bit index.
- Used only under `INTR_VECTOR_EN`.

## Test plan
- **Reset:** drive `reset`=0 with all lines high -> `takenInterrupt`=0. Reads of regs 12, 13 and 14 return 0. `handler_pc`=32'h8000_0180.
- **Basic accept:** MTC0 Status=32'h0000_8001; raise line 7 -> `takenInterrupt` for exactly one cycle, one cycle after the line rise. EPC=`next_pc`=32'h0040_0100. Status reads 32'h0000_8003.
- **Masking and stall:**
  - IM=0 with line 7 high -> no interrupt.
  - `stall`=1 for 3 cycles with IM set -> interrupt in the first cycle with `stall`=0.
- **ERET and re-entry:** in the handler, ERET with the line dropped -> EXL=0 and no interrupt. Line held high across ERET -> interrupt one cycle after EXL clears.
- **Collision:** `takenInterrupt`, ERET and MTC0 EPC=32'h1234 in the same cycle -> EXL=1 and EPC=`next_pc`; 32'h1234 is discarded.
- **Vectoring (`INTR_VECTOR_EN`):** lines 2 and 5 pending, both unmasked -> `handler_pc`=32'h8000_01C0.
